motor_ramp_ctrl: RTL and testbench
==================================

# motor_ramp_ctrl

Two-channel soft-start and safe-reversal controller for the RC car drive motors. It accepts duty/direction commands over a valid/ready handshake. It ramps each channel's duty one step per ramp tick toward the commanded target. Before any direction reversal it ramps to zero and then holds a coast dead-time. Its duty outputs drive the `duty` inputs of two `pwm_100` instances, and its direction outputs drive the H-bridge IN1/IN2 pins.

## Interface
- STEP_CYCLES, 1_000_000: clk cycles per ramp tick (≥2); 10 ms at 100 MHz.
- DEAD_CYCLES, 5_000_000: clk cycles of coast (dir 2'b00) between direction changes (≥1).
- clk  in  1  system clock.
- reset_p  in  1  asynchronous, active-high reset.
- estop  in  1  synchronous emergency stop, level-sensitive.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge.
- cmd_ch  in  1  target channel: 0 = left, 1 = right.
- cmd_dir  in  1  0 = forward, 1 = reverse.
- cmd_duty  in  7  target duty in percent; values above 100 are clamped to 100.
- duty_l, duty_r  out  7  current duty, to `pwm_100`.
- dir_l, dir_r  out  2  2'b01 = forward, 2'b10 = reverse, 2'b00 = coast.
- busy_l, busy_r  out  1  channel not in IDLE.

## Operation
- Shared ramp-tick counter runs 0..STEP_CYCLES-1. It emits a 1-cycle `tick` when the count equals STEP_CYCLES-1, then wraps to 0. It is free-running and is not reset by commands.
- Per-channel registers:
  - state (IDLE, RAMP, BRAKE, DEAD)
  - duty
  - target
  - cur_dir
  - pend_dir
  - dir_valid
  - dead counter
- Reset and estop both force: state IDLE, duty 0, target 0, dir_valid 0, dir output 2'b00.
- Dir output: 2'b00 when !dir_valid or state == DEAD; otherwise it is the encoding of cur_dir.
- cmd_ready = !estop && (state[cmd_ch] != DEAD).
- On command accept, for channel `c`:
  - target ← clamp(cmd_duty).
  - If !dir_valid or cmd_dir == cur_dir or (duty == 0 and state != DEAD):
    - cur_dir ← cmd_dir, dir_valid ← 1.
    - If dir_valid was 1 and the direction changed with duty 0: go to DEAD, dead counter = DEAD_CYCLES-1.
    - Otherwise go to RAMP, or to IDLE if target == duty.
  - Else (direction change with duty > 0): pend_dir ← cmd_dir, go to BRAKE.
- A new command accepted during BRAKE updates target and pend_dir and stays in BRAKE. If the new direction equals cur_dir, go to RAMP toward the new target instead.
- RAMP: on each tick, duty moves ±1 toward target. When duty == target after the update, go to IDLE.
- BRAKE: on each tick, duty decrements by 1. When duty reaches 0, go to DEAD with dead counter = DEAD_CYCLES-1.
- DEAD: counter decrements every clk. At 0: cur_dir ← pend_dir, then go to RAMP (or to IDLE if target == 0).
- Duty never exceeds 100 and never underflows below 0.
- Channels are fully independent apart from the shared tick and the single command port.

## Timing
- Command accepted at edge N: state and target update at edge N. Duty first changes on the first tick after N, never at N itself.
- Duty changes only on tick edges, by exactly 1 per tick.
- Ramp from 0 to D takes D ticks; reversal from duty D takes D ticks + DEAD_CYCLES clk + the ramp up to the new target.
- dir changes from 2'b00 to the new code on the same edge that DEAD exits.
- estop has priority over a simultaneous command and over tick. Outputs are zero one edge after estop is sampled high.
- Deasserting estop leaves the channel in IDLE with dir 2'b00 until the next command.
- Asynchronous reset mid-ramp immediately forces all outputs to their reset values: duty 0, dir 2'b00, busy 0, cmd_ready 0 while reset_p is high.

## Structure
- Shared package:
  - state enum (IDLE/RAMP/BRAKE/DEAD)
  - DIR_FWD = 2'b01, DIR_REV = 2'b10, DIR_COAST = 2'b00
  - DUTY_MAX = 7'd100
- Sub-module `motor_ramp_channel`: per-channel FSM, duty, and dead counter. It is instantiated twice.
- The top module holds the tick counter, cmd_ready mux, and command demux.

## Test plan
Bench uses STEP_CYCLES = 4, DEAD_CYCLES = 8.
- Fresh reset, then cmd ch0/fwd/duty 5 → dir_l = 01 immediately; duty_l goes 1..5 on 5 successive ticks; busy_l drops on the tick where duty hits 5; right channel untouched.
- cmd ch1/duty 120 → target clamps to 100; duty_r stops at 100 after 100 ticks.
- ch0 at duty 3 fwd, cmd rev/duty 2 → duty_l goes 2, 1, 0 over 3 ticks; dir_l = 00 for exactly 8 clk; cmd_ready low when cmd_ch = 0 during DEAD; dir_l = 10, then duty_l ramps to 2.
- During BRAKE, cmd ch0/fwd/duty 4 → BRAKE is aborted, no DEAD phase, duty_l ramps up to 4 with dir_l staying 01.
- estop asserted mid-ramp with simultaneous cmd_valid → cmd_ready = 0; duty and dir both 0/00 next edge; command dropped; after release, channel is IDLE until a new command.
- reset_p pulsed asynchronously between clock edges during a ramp → all outputs at reset values before the next posedge.

Source files
------------

// File: rtl/motor_ramp_ctrl_pkg.sv
// Shared types and constants for the two-channel motor soft-start / safe-reversal controller.
package motor_ramp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_BRAKE = 2'd2,
        ST_DEAD  = 2'd3
    } ch_state_t;

    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;

    localparam logic [6:0] DUTY_MAX  = 7'd100;

    function automatic logic [6:0] clamp_duty(input logic [6:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    function automatic logic [1:0] dir_code(input logic rev);
        return rev ? DIR_REV : DIR_FWD;
    endfunction

endpackage

// File: rtl/motor_ramp_ctrl_if.sv
// Command port of the motor ramp controller: valid/ready handshake carrying channel, direction and duty.
interface motor_ramp_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_ch;
    logic       cmd_dir;
    logic [6:0] cmd_duty;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_dir,
        output cmd_duty,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_dir,
        input  cmd_duty,
        output cmd_ready
    );

endinterface

// File: rtl/motor_ramp_channel.sv
// One motor channel: ramps duty toward target one step per tick, and brakes to zero plus a
// coast dead-time before any direction reversal.
module motor_ramp_channel
    import motor_ramp_ctrl_pkg::*;
#(
    parameter int DEAD_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       estop,
    input  logic       tick,
    input  logic       accept,
    input  logic       cmd_dir,
    input  logic [6:0] cmd_duty,
    output logic [6:0] duty,
    output logic [1:0] dir,
    output logic       busy,
    output logic       in_dead
);

    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);

    ch_state_t     state, state_n;
    logic [6:0]    duty_n;
    logic [6:0]    target, target_n;
    logic          cur_dir, cur_dir_n;
    logic          pend_dir, pend_dir_n;
    logic          dir_valid, dir_valid_n;
    logic [DW-1:0] dead_cnt, dead_cnt_n;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state     <= ST_IDLE;
            duty      <= '0;
            target    <= '0;
            cur_dir   <= 1'b0;
            pend_dir  <= 1'b0;
            dir_valid <= 1'b0;
            dead_cnt  <= '0;
        end else begin
            state     <= state_n;
            duty      <= duty_n;
            target    <= target_n;
            cur_dir   <= cur_dir_n;
            pend_dir  <= pend_dir_n;
            dir_valid <= dir_valid_n;
            dead_cnt  <= dead_cnt_n;
        end
    end

    // An accepted command takes precedence over a coincident tick, so duty never moves on the accept edge.
    always_comb begin
        state_n     = state;
        duty_n      = duty;
        target_n    = target;
        cur_dir_n   = cur_dir;
        pend_dir_n  = pend_dir;
        dir_valid_n = dir_valid;
        dead_cnt_n  = dead_cnt;

        if (estop) begin
            state_n     = ST_IDLE;
            duty_n      = '0;
            target_n    = '0;
            dir_valid_n = 1'b0;
        end else if (accept) begin
            target_n = cmd_duty;
            if (!dir_valid || (cmd_dir == cur_dir) || (duty == '0 && state != ST_DEAD)) begin
                cur_dir_n   = cmd_dir;
                pend_dir_n  = cmd_dir;
                dir_valid_n = 1'b1;
                if (dir_valid && (cmd_dir != cur_dir)) begin
                    state_n    = ST_DEAD;
                    dead_cnt_n = DEAD_LOAD;
                end else begin
                    state_n = (cmd_duty == duty) ? ST_IDLE : ST_RAMP;
                end
            end else begin
                pend_dir_n = cmd_dir;
                state_n    = ST_BRAKE;
            end
        end else begin
            unique case (state)
                ST_RAMP: begin
                    if (tick) begin
                        if (duty < target) begin
                            duty_n = duty + 7'd1;
                        end else if (duty > target) begin
                            duty_n = duty - 7'd1;
                        end
                        if (duty_n == target) begin
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_BRAKE: begin
                    if (tick) begin
                        duty_n = (duty != '0) ? duty - 7'd1 : '0;
                        if (duty_n == '0) begin
                            state_n    = ST_DEAD;
                            dead_cnt_n = DEAD_LOAD;
                        end
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt == '0) begin
                        cur_dir_n = pend_dir;
                        state_n   = (target == '0) ? ST_IDLE : ST_RAMP;
                    end else begin
                        dead_cnt_n = dead_cnt - DW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dir     = (!dir_valid || state == ST_DEAD) ? DIR_COAST : dir_code(cur_dir);
    assign busy    = (state != ST_IDLE);
    assign in_dead = (state == ST_DEAD);

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Two-channel motor ramp controller: shared ramp-tick generator, command demux and per-channel
// ramp/brake/dead-time engines feeding the pwm_100 duty inputs and H-bridge direction pins.
module motor_ramp_ctrl
    import motor_ramp_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES = 1_000_000,
    parameter int DEAD_CYCLES = 5_000_000
) (
    input  logic                     clk,
    input  logic                     reset_p,
    input  logic                     estop,
    motor_ramp_ctrl_if.slave         cmd,
    output logic [6:0]               duty_l,
    output logic [6:0]               duty_r,
    output logic [1:0]               dir_l,
    output logic [1:0]               dir_r,
    output logic                     busy_l,
    output logic                     busy_r
);

    localparam int TW = $clog2(STEP_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          dead_l, dead_r;
    logic          accept, accept_l, accept_r;
    logic [6:0]    duty_clamped;

    // Free-running tick counter, independent of command traffic.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    assign cmd.cmd_ready = !reset_p && !estop && !(cmd.cmd_ch ? dead_r : dead_l);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign accept_l      = accept && !cmd.cmd_ch;
    assign accept_r      = accept && cmd.cmd_ch;
    assign duty_clamped  = clamp_duty(cmd.cmd_duty);

    motor_ramp_channel #(
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_chan_l (
        .clk      (clk),
        .reset_p  (reset_p),
        .estop    (estop),
        .tick     (tick),
        .accept   (accept_l),
        .cmd_dir  (cmd.cmd_dir),
        .cmd_duty (duty_clamped),
        .duty     (duty_l),
        .dir      (dir_l),
        .busy     (busy_l),
        .in_dead  (dead_l)
    );

    motor_ramp_channel #(
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_chan_r (
        .clk      (clk),
        .reset_p  (reset_p),
        .estop    (estop),
        .tick     (tick),
        .accept   (accept_r),
        .cmd_dir  (cmd.cmd_dir),
        .cmd_duty (duty_clamped),
        .duty     (duty_r),
        .dir      (dir_r),
        .busy     (busy_r),
        .in_dead  (dead_r)
    );

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed scenarios plus random traffic, checked against a
// behavioural model of duty/target/direction kept as plain integers.
module tb_motor_ramp_ctrl;

    localparam int STEP_CYCLES = 4;
    localparam int DEAD_CYCLES = 8;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       estop;
    logic [6:0] duty_l, duty_r;
    logic [1:0] dir_l, dir_r;
    logic       busy_l, busy_r;

    motor_ramp_ctrl_if cmd_if();

    int n_checks = 0;
    int n_errors = 0;

    int m_duty[2];
    int m_target[2];
    int m_dead[2];
    bit m_cur[2];
    bit m_pend[2];
    bit m_valid[2];
    bit m_brake[2];
    int m_cyc;
    bit m_tick;
    bit m_acc;
    bit m_d;
    int m_clamped;

    motor_ramp_ctrl #(
        .STEP_CYCLES (STEP_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .estop   (estop),
        .cmd     (cmd_if),
        .duty_l  (duty_l),
        .duty_r  (duty_r),
        .dir_l   (dir_l),
        .dir_r   (dir_r),
        .busy_l  (busy_l),
        .busy_r  (busy_r)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy(input int c);
        return m_brake[c] || (m_dead[c] > 0) || (m_duty[c] != m_target[c]);
    endfunction

    function automatic logic [1:0] m_dir(input int c);
        if (!m_valid[c] || m_dead[c] > 0) return 2'b00;
        return m_cur[c] ? 2'b10 : 2'b01;
    endfunction

    function automatic bit m_ready();
        return !reset_p && !estop && (m_dead[cmd_if.cmd_ch] == 0);
    endfunction

    // Reference model: duty walks toward target per tick; a reversal with nonzero duty brakes
    // to zero first, then the channel coasts for DEAD_CYCLES clocks before taking the new direction.
    initial begin
        forever begin
            @(posedge clk or posedge reset_p);
            if (reset_p) begin
                m_cyc = 0;
                for (int c = 0; c < 2; c++) begin
                    m_duty[c] = 0; m_target[c] = 0; m_dead[c] = 0;
                    m_cur[c] = 0; m_pend[c] = 0; m_valid[c] = 0; m_brake[c] = 0;
                end
            end else begin
                m_tick    = (m_cyc % STEP_CYCLES) == (STEP_CYCLES - 1);
                m_acc     = cmd_if.cmd_valid && m_ready();
                m_d       = cmd_if.cmd_dir;
                m_clamped = (int'(cmd_if.cmd_duty) > 100) ? 100 : int'(cmd_if.cmd_duty);
                m_cyc++;
                for (int c = 0; c < 2; c++) begin
                    if (estop) begin
                        m_duty[c] = 0; m_target[c] = 0; m_valid[c] = 0;
                        m_brake[c] = 0; m_dead[c] = 0;
                    end else if (m_acc && int'(cmd_if.cmd_ch) == c) begin
                        m_target[c] = m_clamped;
                        if (!m_valid[c] || m_d == m_cur[c] || m_duty[c] == 0) begin
                            if (m_valid[c] && m_d != m_cur[c]) m_dead[c] = DEAD_CYCLES;
                            m_cur[c] = m_d; m_pend[c] = m_d; m_valid[c] = 1; m_brake[c] = 0;
                        end else begin
                            m_pend[c] = m_d; m_brake[c] = 1;
                        end
                    end else if (m_dead[c] > 0) begin
                        m_dead[c]--;
                        if (m_dead[c] == 0) m_cur[c] = m_pend[c];
                    end else if (m_tick) begin
                        if (m_brake[c]) begin
                            m_duty[c]--;
                            if (m_duty[c] == 0) begin
                                m_brake[c] = 0;
                                m_dead[c] = DEAD_CYCLES;
                            end
                        end else if (m_duty[c] < m_target[c]) begin
                            m_duty[c]++;
                        end else if (m_duty[c] > m_target[c]) begin
                            m_duty[c]--;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input bit ch, input bit d, input int duty);
        cmd_if.cmd_ch    = ch;
        cmd_if.cmd_dir   = d;
        cmd_if.cmd_duty  = 7'(duty);
        cmd_if.cmd_valid = 1'b1;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic settle(input int c);
        int budget = 1000;
        while (m_busy(c) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++; n_errors++;
            $display("[TB] FAIL settle_timeout ch%0d got busy want idle", c);
        end
    endtask

    task automatic test_reset();
        reset_p = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (duty_l !== 7'd0)  begin n_errors++; $display("[TB] FAIL rst_duty_l got %0d want 0", duty_l); end
        n_checks++; if (dir_l !== 2'b00)  begin n_errors++; $display("[TB] FAIL rst_dir_l got %b want 00", dir_l); end
        n_checks++; if (busy_l !== 1'b0)  begin n_errors++; $display("[TB] FAIL rst_busy_l got %b want 0", busy_l); end
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL rst_ready_in_reset got %b want 0", cmd_if.cmd_ready); end
        reset_p = 1'b0;
        @(negedge clk);
        n_checks++; if (duty_r !== 7'd0)  begin n_errors++; $display("[TB] FAIL rst_duty_r got %0d want 0", duty_r); end
        n_checks++; if (dir_r !== 2'b00)  begin n_errors++; $display("[TB] FAIL rst_dir_r got %b want 00", dir_r); end
        n_checks++; if (busy_r !== 1'b0)  begin n_errors++; $display("[TB] FAIL rst_busy_r got %b want 0", busy_r); end
        n_checks++; if (cmd_if.cmd_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL rst_ready_after got %b want 1", cmd_if.cmd_ready); end
    endtask

    task automatic test_ramp_up();
        int budget = 100;
        int changes = 0;
        logic [6:0] prev = 7'd0;
        send(0, 0, 5);
        n_checks++; if (dir_l !== 2'b01) begin n_errors++; $display("[TB] FAIL ramp_dir_at_accept got %b want 01", dir_l); end
        n_checks++; if (duty_l !== 7'd0) begin n_errors++; $display("[TB] FAIL ramp_duty_at_accept got %0d want 0", duty_l); end
        n_checks++; if (busy_l !== 1'b1) begin n_errors++; $display("[TB] FAIL ramp_busy_at_accept got %b want 1", busy_l); end
        while (m_busy(0) && budget > 0) begin
            @(negedge clk);
            budget--;
            n_checks++; if (duty_l !== 7'(m_duty[0])) begin n_errors++; $display("[TB] FAIL ramp_duty_l got %0d want %0d", duty_l, m_duty[0]); end
            n_checks++; if (busy_l !== m_busy(0)) begin n_errors++; $display("[TB] FAIL ramp_busy_l got %b want %b", busy_l, m_busy(0)); end
            n_checks++; if (duty_r !== 7'd0 || dir_r !== 2'b00) begin n_errors++; $display("[TB] FAIL ramp_right_touched got %0d/%b want 0/00", duty_r, dir_r); end
            if (duty_l !== prev) begin
                changes++;
                n_checks++; if (duty_l !== prev + 7'd1) begin n_errors++; $display("[TB] FAIL ramp_step got %0d want %0d", duty_l, prev + 7'd1); end
                prev = duty_l;
            end
        end
        n_checks++; if (budget == 0) begin n_errors++; $display("[TB] FAIL ramp_timeout got busy want idle"); end
        n_checks++; if (changes != 5) begin n_errors++; $display("[TB] FAIL ramp_step_count got %0d want 5", changes); end
        n_checks++; if (duty_l !== 7'd5 || busy_l !== 1'b0) begin n_errors++; $display("[TB] FAIL ramp_final got %0d/%b want 5/0", duty_l, busy_l); end
    endtask

    task automatic test_clamp();
        int budget = 600;
        send(1, 0, 120);
        while (m_busy(1) && budget > 0) begin
            @(negedge clk);
            budget--;
            n_checks++; if (duty_r !== 7'(m_duty[1])) begin n_errors++; $display("[TB] FAIL clamp_duty_r got %0d want %0d", duty_r, m_duty[1]); end
            n_checks++; if (dir_r !== m_dir(1)) begin n_errors++; $display("[TB] FAIL clamp_dir_r got %b want %b", dir_r, m_dir(1)); end
        end
        n_checks++; if (budget == 0) begin n_errors++; $display("[TB] FAIL clamp_timeout got busy want idle"); end
        repeat (2 * STEP_CYCLES) @(negedge clk);
        n_checks++; if (duty_r !== 7'd100 || busy_r !== 1'b0) begin n_errors++; $display("[TB] FAIL clamp_final got %0d/%b want 100/0", duty_r, busy_r); end
        n_checks++; if (duty_l !== 7'd5) begin n_errors++; $display("[TB] FAIL clamp_left_touched got %0d want 5", duty_l); end
    endtask

    task automatic test_brake_abort();
        int budget = 100;
        send(0, 0, 3);
        settle(0);
        n_checks++; if (duty_l !== 7'd3) begin n_errors++; $display("[TB] FAIL abort_start got %0d want 3", duty_l); end
        send(0, 1, 2);
        n_checks++; if (dir_l !== 2'b01 || busy_l !== 1'b1) begin n_errors++; $display("[TB] FAIL abort_brake_enter got %b/%b want 01/1", dir_l, busy_l); end
        while (m_duty[0] == 3 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_checks++; if (duty_l !== 7'd2) begin n_errors++; $display("[TB] FAIL abort_brake_step got %0d want 2", duty_l); end
        send(0, 0, 4);
        budget = 100;
        while (m_busy(0) && budget > 0) begin
            @(negedge clk);
            budget--;
            n_checks++; if (duty_l !== 7'(m_duty[0])) begin n_errors++; $display("[TB] FAIL abort_duty_l got %0d want %0d", duty_l, m_duty[0]); end
            n_checks++; if (dir_l !== 2'b01) begin n_errors++; $display("[TB] FAIL abort_dir_l got %b want 01", dir_l); end
        end
        n_checks++; if (duty_l !== 7'd4 || busy_l !== 1'b0) begin n_errors++; $display("[TB] FAIL abort_final got %0d/%b want 4/0", duty_l, busy_l); end
    endtask

    task automatic test_reversal();
        int budget = 300;
        int coast = 0;
        bit probed = 0;
        send(0, 0, 3);
        settle(0);
        n_checks++; if (duty_l !== 7'd3) begin n_errors++; $display("[TB] FAIL rev_start got %0d want 3", duty_l); end
        send(0, 1, 2);
        while (m_busy(0) && budget > 0) begin
            @(negedge clk);
            budget--;
            n_checks++; if (duty_l !== 7'(m_duty[0])) begin n_errors++; $display("[TB] FAIL rev_duty_l got %0d want %0d", duty_l, m_duty[0]); end
            n_checks++; if (dir_l !== m_dir(0)) begin n_errors++; $display("[TB] FAIL rev_dir_l got %b want %b", dir_l, m_dir(0)); end
            n_checks++; if (cmd_if.cmd_ready !== (m_dead[0] == 0)) begin n_errors++; $display("[TB] FAIL rev_ready_ch0 got %b want %b", cmd_if.cmd_ready, m_dead[0] == 0); end
            if (dir_l === 2'b00) coast++;
            if (m_dead[0] > 0 && !probed) begin
                probed = 1;
                cmd_if.cmd_ch = 1'b1;
                #1;
                n_checks++; if (cmd_if.cmd_ready !== 1'b1) begin n_errors++; $display("[TB] FAIL rev_ready_ch1 got %b want 1", cmd_if.cmd_ready); end
                cmd_if.cmd_ch = 1'b0;
            end
        end
        n_checks++; if (budget == 0) begin n_errors++; $display("[TB] FAIL rev_timeout got busy want idle"); end
        n_checks++; if (coast != DEAD_CYCLES) begin n_errors++; $display("[TB] FAIL rev_coast_len got %0d want %0d", coast, DEAD_CYCLES); end
        n_checks++; if (duty_l !== 7'd2 || dir_l !== 2'b10) begin n_errors++; $display("[TB] FAIL rev_final got %0d/%b want 2/10", duty_l, dir_l); end
    endtask

    task automatic test_estop();
        send(1, 0, 50);
        repeat (10) @(negedge clk);
        estop            = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 1'b1;
        cmd_if.cmd_dir   = 1'b1;
        cmd_if.cmd_duty  = 7'd30;
        #1;
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL estop_ready got %b want 0", cmd_if.cmd_ready); end
        @(negedge clk);
        n_checks++; if (duty_r !== 7'd0 || dir_r !== 2'b00 || busy_r !== 1'b0) begin n_errors++; $display("[TB] FAIL estop_right got %0d/%b/%b want 0/00/0", duty_r, dir_r, busy_r); end
        n_checks++; if (duty_l !== 7'd0 || dir_l !== 2'b00) begin n_errors++; $display("[TB] FAIL estop_left got %0d/%b want 0/00", duty_l, dir_l); end
        estop            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            n_checks++; if (duty_r !== 7'd0 || dir_r !== 2'b00 || busy_r !== 1'b0) begin n_errors++; $display("[TB] FAIL estop_release got %0d/%b/%b want 0/00/0", duty_r, dir_r, busy_r); end
        end
        send(1, 0, 2);
        settle(1);
        n_checks++; if (duty_r !== 7'd2 || dir_r !== 2'b01) begin n_errors++; $display("[TB] FAIL estop_recover got %0d/%b want 2/01", duty_r, dir_r); end
    endtask

    task automatic test_async_reset();
        send(0, 0, 20);
        repeat (9) @(negedge clk);
        n_checks++; if (duty_l !== 7'(m_duty[0]) || duty_l === 7'd0) begin n_errors++; $display("[TB] FAIL arst_pre got %0d want %0d (nonzero)", duty_l, m_duty[0]); end
        #2;
        reset_p = 1'b1;
        #1;
        n_checks++; if (duty_l !== 7'd0 || dir_l !== 2'b00 || busy_l !== 1'b0) begin n_errors++; $display("[TB] FAIL arst_left got %0d/%b/%b want 0/00/0", duty_l, dir_l, busy_l); end
        n_checks++; if (duty_r !== 7'd0 || dir_r !== 2'b00 || busy_r !== 1'b0) begin n_errors++; $display("[TB] FAIL arst_right got %0d/%b/%b want 0/00/0", duty_r, dir_r, busy_r); end
        n_checks++; if (cmd_if.cmd_ready !== 1'b0) begin n_errors++; $display("[TB] FAIL arst_ready got %b want 0", cmd_if.cmd_ready); end
        @(negedge clk);
        reset_p = 1'b0;
        @(negedge clk);
        n_checks++; if (duty_l !== 7'd0 || busy_l !== 1'b0) begin n_errors++; $display("[TB] FAIL arst_after got %0d/%b want 0/0", duty_l, busy_l); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_checks++; if (duty_l !== 7'(m_duty[0])) begin n_errors++; $display("[TB] FAIL rand_duty_l cyc %0d got %0d want %0d", i, duty_l, m_duty[0]); end
            n_checks++; if (duty_r !== 7'(m_duty[1])) begin n_errors++; $display("[TB] FAIL rand_duty_r cyc %0d got %0d want %0d", i, duty_r, m_duty[1]); end
            n_checks++; if (dir_l !== m_dir(0)) begin n_errors++; $display("[TB] FAIL rand_dir_l cyc %0d got %b want %b", i, dir_l, m_dir(0)); end
            n_checks++; if (dir_r !== m_dir(1)) begin n_errors++; $display("[TB] FAIL rand_dir_r cyc %0d got %b want %b", i, dir_r, m_dir(1)); end
            n_checks++; if (busy_l !== m_busy(0)) begin n_errors++; $display("[TB] FAIL rand_busy_l cyc %0d got %b want %b", i, busy_l, m_busy(0)); end
            n_checks++; if (busy_r !== m_busy(1)) begin n_errors++; $display("[TB] FAIL rand_busy_r cyc %0d got %b want %b", i, busy_r, m_busy(1)); end
            cmd_if.cmd_valid = ($urandom_range(0, 19) == 0);
            cmd_if.cmd_ch    = 1'($urandom_range(0, 1));
            cmd_if.cmd_dir   = 1'($urandom_range(0, 1));
            cmd_if.cmd_duty  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 8));
            estop            = ($urandom_range(0, 149) == 0);
            #1;
            n_checks++; if (cmd_if.cmd_ready !== m_ready()) begin n_errors++; $display("[TB] FAIL rand_ready cyc %0d got %b want %b", i, cmd_if.cmd_ready, m_ready()); end
        end
        cmd_if.cmd_valid = 1'b0;
        estop            = 1'b0;
    endtask

    initial begin
        reset_p          = 1'b1;
        estop            = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ch    = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_duty  = 7'd0;
        @(negedge clk);
        test_reset();
        test_ramp_up();
        test_clamp();
        test_brake_abort();
        test_reversal();
        test_estop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
